// File: rtl/bus_slave_port_if.sv
// Shared-bus signals between the bus master/decoder side and one slave port.
interface bus_slave_port_if;
    logic        cs_;
    logic        as_;
    logic        rw;
    logic [29:0] addr;
    logic [31:0] wr_data;
    logic        rdy_;
    logic [31:0] rd_data;
    logic        timeout;

    modport master (
        output cs_, as_, rw, addr, wr_data,
        input  rdy_, rd_data, timeout
    );

    modport slave (
        input  cs_, as_, rw, addr, wr_data,
        output rdy_, rd_data, timeout
    );
endinterface

// File: rtl/bus_slave_port.sv
// Bus slave responder: turns one bus access into a single-outstanding backend req/ack.
// Optional BUS_SLAVE_TIMEOUT_EN forces completion after TIMEOUT cycles without be_ack.
module bus_slave_port #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    bus_slave_port_if.slave   bus,
    output logic              be_req,
    output logic              be_we,
    output logic [ADDR_W-1:0] be_addr,
    output logic [31:0]       be_wdata,
    input  logic              be_ack,
    input  logic [31:0]       be_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                be_req_q, be_req_d;
    logic                be_we_q, be_we_d;
    logic [ADDR_W-1:0]   be_addr_q, be_addr_d;
    logic [31:0]         be_wdata_q, be_wdata_d;
    logic                rdy_q, rdy_d;
    logic [31:0]         rd_data_q, rd_data_d;
    logic                timeout_q, timeout_d;

`ifdef BUS_SLAVE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`else
    logic                unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT;
`endif

    logic                unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[29:ADDR_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            be_req_q   <= 1'b0;
            be_we_q    <= 1'b0;
            be_addr_q  <= '0;
            be_wdata_q <= '0;
            rdy_q      <= 1'b1;
            rd_data_q  <= '0;
            timeout_q  <= 1'b0;
`ifdef BUS_SLAVE_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            be_req_q   <= be_req_d;
            be_we_q    <= be_we_d;
            be_addr_q  <= be_addr_d;
            be_wdata_q <= be_wdata_d;
            rdy_q      <= rdy_d;
            rd_data_q  <= rd_data_d;
            timeout_q  <= timeout_d;
`ifdef BUS_SLAVE_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // Completion outputs default to their inactive values, so they pulse for one cycle.
    always_comb begin
        state_d    = state_q;
        be_req_d   = be_req_q;
        be_we_d    = be_we_q;
        be_addr_d  = be_addr_q;
        be_wdata_d = be_wdata_q;
        rdy_d      = 1'b1;
        rd_data_d  = '0;
        timeout_d  = 1'b0;
`ifdef BUS_SLAVE_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (!bus.cs_ && !bus.as_) begin
                    be_we_d    = ~bus.rw;
                    be_addr_d  = bus.addr[ADDR_W-1:0];
                    be_wdata_d = bus.wr_data;
                    be_req_d   = 1'b1;
`ifdef BUS_SLAVE_TIMEOUT_EN
                    cnt_d      = CNT_W'(TIMEOUT);
`endif
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (be_ack) begin
                    be_req_d  = 1'b0;
                    rdy_d     = 1'b0;
                    rd_data_d = be_we_q ? 32'd0 : be_rdata;
                    state_d   = DONE;
                end
`ifdef BUS_SLAVE_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    be_req_d  = 1'b0;
                    rdy_d     = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign be_req      = be_req_q;
    assign be_we       = be_we_q;
    assign be_addr     = be_addr_q;
    assign be_wdata    = be_wdata_q;
    assign bus.rdy_    = rdy_q;
    assign bus.rd_data = rd_data_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_bus_slave_port.sv
// Self-checking bench for bus_slave_port: directed cases plus random transactions vs. a timing model.
// Honours BUS_SLAVE_TIMEOUT_EN the same way the design does.
module tb_bus_slave_port;

    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned TIMEOUT = 4;

    logic              clk;
    logic              reset;
    logic              be_req;
    logic              be_we;
    logic [ADDR_W-1:0] be_addr;
    logic [31:0]       be_wdata;
    logic              be_ack;
    logic [31:0]       be_rdata;

    int total = 0;
    int bad   = 0;

    bus_slave_port_if bus ();

    bus_slave_port #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .be_req  (be_req),
        .be_we   (be_we),
        .be_addr (be_addr),
        .be_wdata(be_wdata),
        .be_ack  (be_ack),
        .be_rdata(be_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_rdy"}, 32'(bus.rdy_), 32'd1);
        chk({tag, "_req"}, 32'(be_req), 32'd0);
        chk({tag, "_rdata"}, bus.rd_data, 32'd0);
        chk({tag, "_to"}, 32'(bus.timeout), 32'd0);
    endtask

    // One full transaction; backend acks n cycles after acceptance.
    // Model: done n+1 edges after accept, unless timeout applies (n > TIMEOUT).
    task automatic txn(input logic r, input logic [29:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int n);
        logic [31:0] exp_addr;
        bit          to;
        int          wait_n;
        exp_addr = 32'(a) % (32'd1 << ADDR_W);
        to       = 1'b0;
        wait_n   = n;
`ifdef BUS_SLAVE_TIMEOUT_EN
        if (n > int'(TIMEOUT)) begin
            to     = 1'b1;
            wait_n = int'(TIMEOUT);
        end
`endif
        bus.cs_ = 1'b0; bus.as_ = 1'b0; bus.rw = r; bus.addr = a; bus.wr_data = wd;
        be_rdata = $urandom;
        @(negedge clk);
        chk("acc_we", 32'(be_we), 32'(!r));
        chk("acc_wdata", be_wdata, wd);
        bus.cs_ = 1'b1; bus.as_ = 1'b1; bus.rw = ~r;
        bus.addr = 30'($urandom); bus.wr_data = $urandom;
        for (int i = 0; i <= wait_n; i++) begin
            chk("wait_req", 32'(be_req), 32'd1);
            chk("wait_addr", 32'(be_addr), exp_addr);
            chk("wait_rdy", 32'(bus.rdy_), 32'd1);
            if (i < wait_n) @(negedge clk);
        end
        if (!to) begin
            be_ack   = 1'b1;
            be_rdata = rd;
        end
        @(negedge clk);
        be_ack = 1'b0;
        be_rdata = $urandom;
        chk("done_rdy", 32'(bus.rdy_), 32'd0);
        chk("done_rdata", bus.rd_data, (r && !to) ? rd : 32'd0);
        chk("done_to", 32'(bus.timeout), 32'(to));
        chk("done_req", 32'(be_req), 32'd0);
        @(negedge clk);
        check_idle("after");
    endtask

    initial begin
        reset = 1'b1;
        be_ack = 1'b0; be_rdata = '0;
        bus.cs_ = 1'b1; bus.as_ = 1'b1; bus.rw = 1'b1; bus.addr = '0; bus.wr_data = '0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        chk("reset_we", 32'(be_we), 32'd0);
        chk("reset_addr", 32'(be_addr), 32'd0);
        chk("reset_wdata", be_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed: zero-wait read and delayed write.
        txn(1'b1, 30'h0000_0123, 32'h0, 32'hCAFE_F00D, 0);
        txn(1'b0, 30'h0000_0456, 32'h1234_5678, 32'hDEAD_BEEF, 3);

        // Strobe without chip select never starts a transaction.
        bus.cs_ = 1'b1; bus.as_ = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("nosel_req", 32'(be_req), 32'd0);
            chk("nosel_rdy", 32'(bus.rdy_), 32'd1);
        end
        bus.as_ = 1'b1;

        // Stray acknowledge while idle is ignored.
        be_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("stray_ack");
        end
        be_ack = 1'b0;
        @(negedge clk);

        // Busy-ignore, then held strobe is a new access after DONE.
        bus.cs_ = 1'b0; bus.as_ = 1'b0; bus.rw = 1'b1; bus.addr = 30'h0000_0AAA;
        @(negedge clk);
        chk("b2b_addr_a", 32'(be_addr), 32'h0000_0AAA);
        bus.addr = 30'h0000_0555;
        @(negedge clk);
        chk("b2b_ignore", 32'(be_addr), 32'h0000_0AAA);
        chk("b2b_req", 32'(be_req), 32'd1);
        be_ack = 1'b1; be_rdata = 32'h0BAD_CAFE;
        @(negedge clk);
        be_ack = 1'b0;
        chk("b2b_rdy_a", 32'(bus.rdy_), 32'd0);
        chk("b2b_rdata_a", bus.rd_data, 32'h0BAD_CAFE);
        @(negedge clk);
        chk("b2b_done_req", 32'(be_req), 32'd0);
        chk("b2b_done_rdy", 32'(bus.rdy_), 32'd1);
        @(negedge clk);
        chk("b2b_req_b", 32'(be_req), 32'd1);
        chk("b2b_addr_b", 32'(be_addr), 32'h0000_0555);
        bus.cs_ = 1'b1; bus.as_ = 1'b1;
        be_ack = 1'b1; be_rdata = 32'h5555_AAAA;
        @(negedge clk);
        be_ack = 1'b0;
        chk("b2b_rdy_b", 32'(bus.rdy_), 32'd0);
        chk("b2b_rdata_b", bus.rd_data, 32'h5555_AAAA);
        @(negedge clk);
        check_idle("b2b_end");

        // Asynchronous reset in the middle of a request.
        bus.cs_ = 1'b0; bus.as_ = 1'b0; bus.rw = 1'b0; bus.addr = 30'h0000_0777;
        @(negedge clk);
        chk("rst_mid_req", 32'(be_req), 32'd1);
        bus.cs_ = 1'b1; bus.as_ = 1'b1;
        reset = 1'b1;
        #1;
        check_idle("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        txn(1'b1, 30'h0000_0042, 32'h0, 32'h0000_4242, 1);

        // Timeout boundary: ack exactly on the expiry edge, and no ack at all.
        txn(1'b1, 30'h0000_0321, 32'h0, 32'h1357_9BDF, int'(TIMEOUT));
        txn(1'b1, 30'h0000_0654, 32'h0, 32'h2468_ACE0, int'(TIMEOUT) + 3);

        // Random transactions with random gaps.
        for (int k = 0; k < 24; k++) begin
            logic        r;
            logic [29:0] a;
            logic [31:0] wd;
            logic [31:0] rd;
            int          n;
            r  = 1'($urandom);
            a  = 30'($urandom);
            wd = $urandom;
            rd = $urandom;
            n  = int'($urandom_range(0, 7));
            txn(r, a, wd, rd, n);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check_idle("gap");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
